// File: rtl/median_feeder.sv
// median_feeder: gathers an N_PIXELS window from a valid/ready stream, bursts it into the median core over DSI/DI,
// and hands the DO result downstream; a watchdog abandons the window if DSO never comes back.
module median_feeder #(
  parameter int WIDTH    = 8,
  parameter int N_PIXELS = 9,
  parameter int TIMEOUT  = 256
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] PIX_IN,
  input  logic             PIX_VALID,
  output logic             PIX_READY,
  output logic             DSI,
  output logic [WIDTH-1:0] DI,
  input  logic [WIDTH-1:0] DO,
  input  logic             DSO,
  output logic [WIDTH-1:0] MED_OUT,
  output logic             MED_VALID,
  input  logic             MED_READY,
  output logic             ERR
);
  localparam int FW = $clog2(N_PIXELS + 1);
  localparam int SW = $clog2(N_PIXELS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FULL  = FW'(N_PIXELS);
  localparam logic [SW-1:0] LAST  = SW'(N_PIXELS - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t           r_state, w_next;
  logic [FW-1:0]    r_fcnt;
  logic [SW-1:0]    r_scnt;
  logic [TW-1:0]    r_tcnt;
  logic [WIDTH-1:0] r_buf [N_PIXELS];
  logic             w_accept, w_start, w_last, w_hit, w_tout, w_burst;
  logic [SW-1:0]    w_sidx;

  assign PIX_READY = (r_fcnt < FULL) && (r_state != SEND);
  assign w_accept  = PIX_VALID && PIX_READY;

  always_comb begin
    w_start = 1'b0;
    w_last  = 1'b0;
    w_hit   = 1'b0;
    w_tout  = 1'b0;
    w_start = (r_state == IDLE) && (r_fcnt == FULL) && !MED_VALID;
    w_last  = (r_state == SEND) && (r_scnt == LAST);
    w_hit   = (r_state == WAIT) && DSO;
    w_tout  = (r_state == WAIT) && !DSO && (r_tcnt == TLAST);
    w_next  = w_start ? SEND : w_last ? WAIT : (w_hit || w_tout) ? IDLE : r_state;
    // DI is registered, so each edge loads the pixel for the beat that follows it
    w_burst = w_start || ((r_state == SEND) && !w_last);
    w_sidx  = (w_start || w_last) ? '0 : r_scnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_fcnt    <= '0;
      r_scnt    <= '0;
      r_tcnt    <= '0;
      DSI       <= 1'b0;
      DI        <= '0;
      MED_OUT   <= '0;
      MED_VALID <= 1'b0;
      ERR       <= 1'b0;
      for (int i = 0; i < N_PIXELS; i++) r_buf[i] <= '0;
    end else begin
      if (w_accept) r_buf[r_fcnt] <= PIX_IN;
      r_fcnt    <= w_last ? '0 : r_fcnt + FW'(w_accept);
      r_scnt    <= w_start ? '0 : (r_state == SEND) ? r_scnt + 1'b1 : r_scnt;
      r_tcnt    <= w_last ? '0 : ((r_state == WAIT) && (r_tcnt != TMAX)) ? r_tcnt + 1'b1 : r_tcnt;
      DSI       <= w_burst;
      DI        <= w_burst ? r_buf[w_sidx] : '0;
      MED_OUT   <= w_hit ? DO : MED_OUT;
      MED_VALID <= w_hit ? 1'b1 : (MED_VALID && MED_READY) ? 1'b0 : MED_VALID;
      ERR       <= w_tout;
    end
  end
endmodule
